// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for the FIFO frame reader.
//
// Holds the two-bit word-type tags placed in the top bits of every output
// word, the reader FSM state encoding, counter widths and the bit offsets
// of the trailer fields. The offsets are relative to a 38-bit field block.
// That block is left-justified inside the payload when DATA_WIDTH > 40.
package fifo_frame_reader_pkg;

  // Word-type tags carried in outData[DW-1:DW-2].
  localparam logic [1:0] WT_FILLER  = 2'b00;
  localparam logic [1:0] WT_HEADER  = 2'b01;
  localparam logic [1:0] WT_DATA    = 2'b10;
  localparam logic [1:0] WT_TRAILER = 2'b11;

  // Reader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TRAIL = 2'd2
  } state_t;

  // Counter widths.
  localparam int FCNT_WIDTH = 12;  // completed-frame counter
  localparam int CNT_WIDTH  = 8;   // data words in the current frame
  localparam int XOR_WIDTH  = 16;  // checksum width
  localparam int RSVD_WIDTH = 2;   // reserved zero bits in the trailer

  // Trailer field block:
  //   [37:26] frameCnt, [25:18] nWords, [17:16] reserved, [15:0] xor16
  localparam int TRL_FIELD_BITS = FCNT_WIDTH + CNT_WIDTH + RSVD_WIDTH + XOR_WIDTH;
  localparam int TRL_XOR_LSB    = 0;
  localparam int TRL_RSVD_LSB   = TRL_XOR_LSB + XOR_WIDTH;
  localparam int TRL_NWORDS_LSB = TRL_RSVD_LSB + RSVD_WIDTH;
  localparam int TRL_FCNT_LSB   = TRL_NWORDS_LSB + CNT_WIDTH;

endpackage

// File: rtl/frame_checksum_acc.sv
// 16-bit XOR accumulator for the frame trailer checksum.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-low reset, clears the sum
//   i_clear   in   clear the sum at this edge (takes priority over i_enable)
//   i_enable  in   fold i_data into the sum at this edge
//   i_data    in   16-bit value to fold in
//   o_sum     out  running XOR of all values folded in since the last clear
module frame_checksum_acc
  import fifo_frame_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [XOR_WIDTH-1:0] i_data,
  output logic [XOR_WIDTH-1:0] o_sum
);

  logic [XOR_WIDTH-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_enable) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/fifo_frame_reader.sv
// FIFO frame reader: the read-side consumer of the hit FIFO.
//
// It pops words from a first-word-fall-through FIFO and wraps them in frames:
// a header, 1..MAX_WORDS data words, then a trailer carrying the word count
// and an XOR checksum. Frames go out on a registered valid/ready stream.
//
// Handshake: a word moves downstream on every rising edge where
// outValid && outReady. outData and outValid change only on "load" edges,
// where load = !outValid || outReady. A word is therefore held stable while
// it waits to be accepted. A FIFO pop (fifoRden) only happens on a load edge
// in which a data word is loaded.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   enable       in   allows new frames to start; a frame in progress completes
//   fifoEmpty    in   FIFO empty flag
//   fifoData     in   FIFO head word (valid while fifoEmpty=0)
//   fifoRden     out  pop strobe, combinational
//   outData      out  registered output word {type[1:0], payload}
//   outValid     out  registered output valid
//   outReady     in   downstream accept
//   frameCnt     out  completed-frame counter, wraps modulo 4096
//   o_dbg_state  out  current FSM state, for observation only
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 40,  // must be >= 40 so the trailer fields fit
  parameter int MAX_WORDS  = 16   // 1..255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifoEmpty,
  input  logic [DATA_WIDTH-3:0] fifoData,
  output logic                  fifoRden,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [FCNT_WIDTH-1:0] frameCnt,
  output state_t                o_dbg_state
);

  localparam int                   PW       = DATA_WIDTH - 2;  // payload width
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_WORDS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [FCNT_WIDTH-1:0] FCNT_ONE = FCNT_WIDTH'(1);

  // Header payload: frame number in the top bits, zeros below.
  function automatic logic [PW-1:0] header_payload(input logic [FCNT_WIDTH-1:0] f);
    return PW'(f) << (PW - FCNT_WIDTH);
  endfunction

  // Registered state.
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [FCNT_WIDTH-1:0] r_frame_cnt;

  // Next-state and control signals.
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [FCNT_WIDTH-1:0] w_fcnt_nxt;
  logic [FCNT_WIDTH-1:0] w_fcnt_inc;
  logic                  w_load;
  logic                  w_room;
  logic                  w_pop;
  logic                  w_sum_clr;
  logic                  w_sum_en;
  logic [XOR_WIDTH-1:0]  w_sum;
  logic [TRL_FIELD_BITS-1:0] w_trl_fields;
  logic [PW-1:0]         w_trl_payload;

  assign w_load     = !r_out_valid || outReady;
  assign w_room     = (r_cnt < MAX_CNT);
  assign w_fcnt_inc = r_frame_cnt + FCNT_ONE;

  // Trailer fields. r_cnt and w_sum already include every data word of the
  // frame, because the trailer is loaded on the edge after the last pop.
  always_comb begin
    w_trl_fields = '0;
    w_trl_fields[TRL_FCNT_LSB +: FCNT_WIDTH]   = r_frame_cnt;
    w_trl_fields[TRL_NWORDS_LSB +: CNT_WIDTH]  = r_cnt;
    w_trl_fields[TRL_RSVD_LSB +: RSVD_WIDTH]   = '0;
    w_trl_fields[TRL_XOR_LSB +: XOR_WIDTH]     = w_sum;
  end

  assign w_trl_payload = PW'(w_trl_fields) << (PW - TRL_FIELD_BITS);

  frame_checksum_acc u_checksum (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_sum_clr),
    .i_enable (w_sum_en),
    .i_data   (fifoData[XOR_WIDTH-1:0]),
    .o_sum    (w_sum)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame_cnt <= w_fcnt_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_out_data;
    w_valid_nxt = r_out_valid;
    w_cnt_nxt   = r_cnt;
    w_fcnt_nxt  = r_frame_cnt;
    w_pop       = 1'b0;
    w_sum_clr   = 1'b0;
    w_sum_en    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          if (enable && !fifoEmpty) begin
            w_data_nxt  = {WT_HEADER, header_payload(r_frame_cnt)};
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_sum_clr   = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (w_load) begin
          if (!fifoEmpty && w_room) begin
            w_pop       = 1'b1;
            w_data_nxt  = {WT_DATA, fifoData};
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = r_cnt + CNT_ONE;
            w_sum_en    = 1'b1;
          end else begin
            // The FIFO ran dry or the frame is full: close the frame now.
            w_data_nxt  = {WT_TRAILER, w_trl_payload};
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_TRAIL;
          end
        end
      end

      ST_TRAIL: begin
        // The trailer is always valid here, so load reduces to outReady.
        if (outReady) begin
          w_fcnt_nxt = w_fcnt_inc;
          if (enable && !fifoEmpty) begin
            // Back-to-back frame: the next header carries the new count.
            w_data_nxt  = {WT_HEADER, header_payload(w_fcnt_inc)};
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_sum_clr   = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Gated by reset so no word is popped and lost while the reader is held.
  assign fifoRden    = w_pop && reset;
  assign outData     = r_out_data;
  assign outValid    = r_out_valid;
  assign frameCnt    = r_frame_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_frame_reader.sv
module tb_fifo_frame_reader;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        fifoEmpty;
  logic [37:0] fifoData;
  logic        fifoRden;
  logic [39:0] outData;
  logic        outValid;
  logic        outReady;
  logic [11:0] frameCnt;
  logic [1:0]  dbg_state;

  fifo_frame_reader #(.DATA_WIDTH(40), .MAX_WORDS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifoEmpty   (fifoEmpty),
    .fifoData    (fifoData),
    .fifoRden    (fifoRden),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady),
    .frameCnt    (frameCnt),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- shared bench state ----------------
  logic [39:0] exp_q[$];
  logic        gap_q[$];   // 1: word must follow the previous transfer with no bubble
  logic [37:0] fifo_q[$];
  logic [37:0] words[0:31];
  int          checks = 0;
  int          errors = 0;
  int          pop_cnt = 0;
  int          fc_model = 0;
  int          cycle = 0;

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [39:0] w, input logic gap);
    exp_q.push_back(w);
    gap_q.push_back(gap);
  endtask

  // Expected frame built from words[base .. base+n-1].
  task automatic push_frame(input int base, input int n, input logic b2b);
    logic [11:0] fc;
    logic [7:0]  nw;
    logic [15:0] x;
    fc = fc_model[11:0];
    nw = n[7:0];
    x  = 16'h0;
    push_exp({2'b01, fc, 26'd0}, b2b);
    for (int i = 0; i < n; i++) begin
      push_exp({2'b10, words[base+i]}, 1'b0);
      x = x ^ words[base+i][15:0];
    end
    push_exp({2'b11, fc, nw, 2'b00, x}, 1'b0);
    fc_model++;
  endtask

  task automatic fifo_push(input int base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(words[base+i]);
  endtask

  // FIFO model: pop decided from fifoRden seen before the edge, applied after it.
  initial begin
    logic pend;
    fifoEmpty = 1'b1;
    fifoData  = '0;
    forever begin
      @(negedge clk);
      pend = fifoRden;
      @(posedge clk);
      #1;
      if (pend) begin
        pop_cnt++;
        if (fifo_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_underflow got=pop want=no_pop");
        end else begin
          void'(fifo_q.pop_front());
        end
      end
      #1;
      fifoEmpty = (fifo_q.size() == 0);
      fifoData  = (fifo_q.size() != 0) ? fifo_q[0] : 38'd0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [39:0] exp_w;
    logic        gap;
    logic [39:0] held;
    logic        was_stalled;
    int          last_xfer;
    was_stalled = 1'b0;
    held = '0;
    last_xfer = -10;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset && outValid && outReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got=%h want=none", outData);
        end else begin
          exp_w = exp_q.pop_front();
          gap   = gap_q.pop_front();
          if (outData !== exp_w) begin
            errors++;
            $display("FAIL out_word got=%h want=%h", outData, exp_w);
          end
          if (gap) begin
            checks++;
            if (cycle != last_xfer + 1) begin
              errors++;
              $display("FAIL no_bubble got=gap_of_%0d want=gap_of_1", cycle - last_xfer);
            end
          end
        end
        last_xfer = cycle;
      end
      if (reset && outValid && !outReady) begin
        checks++;
        if (fifoRden !== 1'b0) begin
          errors++;
          $display("FAIL stall_rden got=%b want=0", fifoRden);
        end
        if (was_stalled) begin
          checks++;
          if (outData !== held) begin
            errors++;
            $display("FAIL stall_hold got=%h want=%h", outData, held);
          end
        end
        held = outData;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (!reset) begin
        checks++;
        if (fifoRden !== 1'b0) begin
          errors++;
          $display("FAIL rden_in_reset got=%b want=0", fifoRden);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    gap_q.delete();
    fc_model = 0;
    pop_cnt = 0;
    @(negedge clk);
    check("rst_outValid", {39'd0, outValid}, 40'd0);
    check("rst_outData", outData, 40'd0);
    check("rst_frameCnt", {28'd0, frameCnt}, 40'd0);
    check("rst_state", {38'd0, dbg_state}, 40'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !outValid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=%0d_pending want=0", name, exp_q.size());
      exp_q.delete();
      gap_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic pat[0:3];
    logic done;
    reset = 1'b0;
    enable = 1'b0;
    outReady = 1'b1;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // 1: three-word frame, checked against hand-computed words.
    do_reset();
    @(posedge clk); #1;
    words[0] = 38'h1_0000_0001;
    words[1] = 38'h1_0000_0002;
    words[2] = 38'h1_0000_0003;
    fifo_push(0, 3);
    push_exp(40'h40_0000_0000, 1'b0);
    push_exp(40'h81_0000_0001, 1'b0);
    push_exp(40'h81_0000_0002, 1'b0);
    push_exp(40'h81_0000_0003, 1'b0);
    push_exp({2'b11, 12'd0, 8'd3, 2'b00, 16'h0000}, 1'b0);
    fc_model = 1;
    enable = 1'b1;
    wait_idle("t1", 100);
    check("t1_pops", 40'(pop_cnt), 40'd3);
    check("t1_frameCnt", {28'd0, frameCnt}, 40'd1);

    // 2: 20 words, MAX_WORDS=16: a full frame then a 4-word frame back to back.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) words[i] = 38'(64'h2_0000_0000 + i * 64'h0001_0007);
    fifo_push(0, 20);
    push_frame(0, 16, 1'b0);
    push_frame(16, 4, 1'b1);
    enable = 1'b1;
    wait_idle("t2", 200);
    check("t2_pops", 40'(pop_cnt), 40'd20);
    check("t2_frameCnt", {28'd0, frameCnt}, 40'd2);

    // 3: five-word frame with outReady stalls.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) words[i] = 38'(64'h3_0000_0000 + i * 64'h0000_1235 + 64'h11);
    fifo_push(0, 5);
    push_frame(0, 5, 1'b0);
    enable = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      outReady = pat[k % 4];
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !outValid) done = 1'b1;
    end
    check("t3_done", {39'd0, done}, 40'd1);
    outReady = 1'b1;
    check("t3_pops", 40'(pop_cnt), 40'd5);
    check("t3_frameCnt", {28'd0, frameCnt}, 40'd1);

    // 4: enable low blocks frames; dropping enable after the header does not.
    do_reset();
    @(posedge clk); #1;
    words[0] = 38'h0_1234_5678;
    words[1] = 38'h0_0000_ABCD;
    fifo_push(0, 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_blocked_valid", {39'd0, outValid}, 40'd0);
    end
    check("t4_blocked_pops", 40'(pop_cnt), 40'd0);
    push_frame(0, 2, 1'b0);
    @(posedge clk); #1;
    enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (outValid) done = 1'b1;
    end
    check("t4_header_seen", {39'd0, done}, 40'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_idle("t4", 50);
    check("t4_pops", 40'(pop_cnt), 40'd2);
    check("t4_frameCnt", {28'd0, frameCnt}, 40'd1);

    // 5: reset after the second data word; a fresh frame follows with count 0.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) words[i] = 38'(64'h0_5000_0000 + i * 64'h0000_0101 + 64'h7);
    fifo_push(0, 5);
    push_exp(40'h40_0000_0000, 1'b0);
    push_exp({2'b10, words[0]}, 1'b0);
    push_exp({2'b10, words[1]}, 1'b0);
    enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    check("t5_two_words_seen", {39'd0, done}, 40'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_valid_after_rst", {39'd0, outValid}, 40'd0);
    check("t5_frameCnt_after_rst", {28'd0, frameCnt}, 40'd0);
    check("t5_rden_after_rst", {39'd0, fifoRden}, 40'd0);
    fc_model = 0;
    // words[2] was popped on the edge before the reset and is lost.
    push_frame(3, 2, 1'b0);
    wait_idle("t5", 50);
    check("t5_pops", 40'(pop_cnt), 40'd5);
    check("t5_frameCnt", {28'd0, frameCnt}, 40'd1);

    // 6: 4097 one-word frames: count wraps 4095 -> 0.
    do_reset();
    enable = 1'b1;
    for (int f = 0; f <= 4096; f++) begin
      @(posedge clk); #1;
      words[0] = 38'(f * 3 + 1);
      fifo_push(0, 1);
      push_frame(0, 1, 1'b0);
      wait_idle("t6", 40);
      if (f == 4095) check("t6_frameCnt_wrap", {28'd0, frameCnt}, 40'd0);
    end
    check("t6_frameCnt_final", {28'd0, frameCnt}, 40'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "time limit reached");
  end

endmodule
